rr_arbiter8: RTL and testbench

- Eight-requester round-robin arbiter with bounded grant hold.
- Sits directly upstream of the 8-to-3 encoder.
- Drives a registered one-hot (or all-zero) grant vector that the encoder converts to a requester index.
- Guarantees the encoder never sees more than one bit set, and gives every persistent requester service within a bounded number of cycles.

---
 rtl/rr_arbiter8.sv | 99 +++++++++
 tb/tb_rr_arbiter8.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold; grant appears 1 cycle after req is sampled.
// No backpressure: owner ends via release_grant or dropping req, else a forced end pulses timeout.
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         release_grant,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [2:0]   ptr, ptr_nxt;
    logic [2:0]   owner, owner_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic [N-1:0] grant_nxt;
    logic         timeout_nxt;
    logic         found;
    logic [2:0]   pick;
    logic [2:0]   idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            owner       <= 3'd0;
            cnt         <= 8'd0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            cnt         <= cnt_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            timeout     <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        grant_nxt   = '0;
        timeout_nxt = 1'b0;
        found       = 1'b0;
        pick        = ptr;
        idx         = ptr;

        case (state)
            IDLE: begin
                // Cyclic search starting at ptr; the 3-bit add wraps 7->0 naturally.
                for (int k = 0; k < 8; k++) begin
                    idx = ptr + 3'(k);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                    cnt_nxt   = 8'd1;
                    grant_nxt = N'(1) << pick;
                end
            end
            GRANT: begin
                if (release_grant || !req[owner] || cnt == MAX_HOLD_C) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = owner + 3'd1;
                    cnt_nxt     = 8'd0;
                    // Voluntary ends take priority, so a forced end only flags when nothing else ended it.
                    timeout_nxt = !release_grant && req[owner];
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                    grant_nxt = grant;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): stimulus queues hand-computed
// per-cycle expectations, a monitor pops and compares one entry after every clock edge.
module tb_rr_arbiter8;

    typedef struct packed {
        logic [7:0] grant;
        logic       timeout;
        logic [7:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       release_grant = 1'b0;
    logic [7:0] grant;
    logic       grant_valid;
    logic       timeout;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic stim_done = 1'b0;

    rr_arbiter8 #(.N(8), .MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .release_grant(release_grant),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic [7:0] rq, input logic rel,
                       input logic [7:0] eg, input logic et, input logic [7:0] tag);
        exp_t e;
        @(negedge clk);
        rst_n         = r;
        req           = rq;
        release_grant = rel;
        e.grant   = eg;
        e.timeout = et;
        e.tag     = tag;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (grant !== e.grant) begin
                    n_fail++;
                    $display("FAIL grant step %0d: got %h expected %h", e.tag, grant, e.grant);
                end
                n_tests++;
                if (grant_valid !== (e.grant != 8'h00)) begin
                    n_fail++;
                    $display("FAIL grant_valid step %0d: got %b expected %b", e.tag, grant_valid, (e.grant != 8'h00));
                end
                n_tests++;
                if (timeout !== e.timeout) begin
                    n_fail++;
                    $display("FAIL timeout step %0d: got %b expected %b", e.tag, timeout, e.timeout);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] g;
        // 1: reset, idle hold, single grant and release
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd1);
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd2);
        cyc(1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 8'd3);
        cyc(1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'd4);
        // 2: all requesting, release on each first grant cycle, rotate 0..7 then wrap to 0
        cyc(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'd5);
        for (int i = 0; i < 9; i++) begin
            g = 8'h01 << (i % 8);
            cyc(1'b1, 8'hFF, 1'b0, g,     1'b0, 8'(10 + 2 * i));
            cyc(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(11 + 2 * i));
        end
        // 3: grant requester 2 moves ptr to 3; search for 8'b101 wraps to bit 0
        cyc(1'b1, 8'h04, 1'b0, 8'h04, 1'b0, 8'd30);
        cyc(1'b1, 8'h04, 1'b1, 8'h00, 1'b0, 8'd31);
        cyc(1'b1, 8'h05, 1'b0, 8'h01, 1'b0, 8'd32);
        cyc(1'b1, 8'h05, 1'b1, 8'h00, 1'b0, 8'd33);
        // 4: persistent req 4 held 4 cycles, forced end with timeout, re-grant after one idle
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 8'(40 + i));
        cyc(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 8'd44);
        cyc(1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 8'd45);
        cyc(1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 8'd46);
        // 5: from ptr=0, 8'h24 grants bit 2; dropping req[2] ends without timeout
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd50);
        cyc(1'b1, 8'h24, 1'b0, 8'h04, 1'b0, 8'd51);
        cyc(1'b1, 8'h24, 1'b0, 8'h04, 1'b0, 8'd52);
        cyc(1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 8'd53);
        cyc(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 8'd54);
        cyc(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 8'd55);
        cyc(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 8'd56);
        cyc(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 8'd57);
        // release coincides with cnt==MAX_HOLD: release wins, no timeout
        cyc(1'b1, 8'h20, 1'b1, 8'h00, 1'b0, 8'd58);
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd59);
        // 6: reset during grant 8'h08 drops it silently and restarts search at 0
        cyc(1'b1, 8'h08, 1'b0, 8'h08, 1'b0, 8'd60);
        cyc(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'd61);
        cyc(1'b1, 8'hFF, 1'b0, 8'h01, 1'b0, 8'd62);
        cyc(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd63);
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd64);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (!stim_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL stimulus_budget: got %0d cycles expected completion", budget);
        end
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
